// File: rtl/switch_post_array.sv
`default_nettype none
// ============================================================================
// Module   : switch_post_array
// Purpose  : Egress buffer stage between the switch core and the per-port MAC
//            transmitters. Cells are steered to NPORTS queues by a multi-hot
//            select. Each queue commits whole frames only and rolls back its
//            write pointer to drop a frame. A 16-bit byte-count word per frame
//            is offered through a fall-through pointer FIFO. Frame data leaves
//            as an OUT_W-bit byte stream, MSB first.
// Ports    : clk, rstn (sync, active-low)
//            o_cell_fifo_wr/sel/din/first/last : cell input from the core
//            o_cell_bp                         : per-port backpressure
//            data_fifo_rd/dout                 : per-port byte stream
//            ptr_fifo_rd/dout/empty            : per-port frame pointer FIFO
//            drop_cnt                          : per-port saturating drop count
// Revision : 1.0 - initial release
// ============================================================================
module switch_post_array #(
    parameter int NPORTS      = 4,
    parameter int CELL_W      = 128,
    parameter int OUT_W       = 8,
    parameter int DEPTH_CELLS = 64,
    parameter int PTR_DEPTH   = 16,
    parameter int BP_MARGIN   = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    o_cell_fifo_wr,
    input  logic [NPORTS-1:0]       o_cell_fifo_sel,
    input  logic [CELL_W-1:0]       o_cell_fifo_din,
    input  logic                    o_cell_first,
    input  logic                    o_cell_last,
    output logic [NPORTS-1:0]       o_cell_bp,
    input  logic [NPORTS-1:0]       data_fifo_rd,
    output logic [NPORTS*OUT_W-1:0] data_fifo_dout,
    input  logic [NPORTS-1:0]       ptr_fifo_rd,
    output logic [NPORTS*16-1:0]    ptr_fifo_dout,
    output logic [NPORTS-1:0]       ptr_fifo_empty,
    output logic [NPORTS*16-1:0]    drop_cnt
);

    localparam int c_AW    = $clog2(DEPTH_CELLS);
    localparam int c_PW    = $clog2(PTR_DEPTH);
    localparam int c_BYTES = CELL_W / OUT_W;
    localparam int c_BW    = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam logic [c_BW-1:0] c_LAST_BYTE = c_BW'(c_BYTES - 1);

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        logic [c_AW:0]      r_wr_ptr, r_frame_start, r_commit_ptr, r_rd_ptr;
        logic               r_in_frame, r_bad;
        logic [c_BW-1:0]    r_byte_idx;
        logic [OUT_W-1:0]   r_dout;
        logic [15:0]        r_drop;
        logic [c_PW:0]      r_pf_wr, r_pf_rd;
        logic [CELL_W-1:0]  r_cell_mem [DEPTH_CELLS];
        logic [15:0]        r_ptr_mem  [PTR_DEPTH];

        logic               w_acc, w_proto_err, w_active, w_full, w_store;
        logic               w_last, w_bad_next, w_pf_empty, w_pop, w_pf_full;
        logic               w_push, w_last_drop, w_rd_ok;
        logic [c_AW:0]      w_base, w_wr_adv, w_fs_next, w_frame_cells, w_used;
        logic [c_PW:0]      w_pf_cnt;
        logic [15:0]        w_frame_bytes;
        logic [16:0]        w_drop_sum;
        logic [CELL_W-1:0]  w_cell_rd;
        logic [OUT_W-1:0]   w_byte;
        logic [31:0]        w_free_cells, w_free_ptrs;

        assign w_acc       = o_cell_fifo_wr & o_cell_fifo_sel[i];
        assign w_proto_err = w_acc & o_cell_first & r_in_frame;
        // A new first cell while a frame is open discards the open frame
        // before the new one starts, so the new frame begins at the old start.
        assign w_base      = w_proto_err ? r_frame_start : r_wr_ptr;
        assign w_active    = w_acc & (o_cell_first | r_in_frame);
        // Full when the pointers alias in the low bits but differ in the MSB.
        assign w_full      = (w_base[c_AW] != r_rd_ptr[c_AW]) &&
                             (w_base[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
        assign w_store     = w_active & ~w_full;
        assign w_wr_adv    = w_base + {{c_AW{1'b0}}, w_store};
        assign w_fs_next   = (w_acc & o_cell_first) ? w_base : r_frame_start;
        assign w_bad_next  = ((w_acc & o_cell_first) ? 1'b0 : r_bad) | (w_active & w_full);
        assign w_last      = w_active & o_cell_last;

        assign w_pf_cnt    = r_pf_wr - r_pf_rd;
        assign w_pf_empty  = (r_pf_wr == r_pf_rd);
        assign w_pop       = ptr_fifo_rd[i] & ~w_pf_empty;
        // A pop in the same cycle frees the slot the push will use.
        assign w_pf_full   = w_pf_cnt[c_PW] & ~w_pop;
        assign w_push      = w_last & ~w_bad_next & ~w_pf_full;
        assign w_last_drop = w_last & ~w_push;

        assign w_frame_cells = w_wr_adv - w_fs_next;
        assign w_frame_bytes = 16'(32'(w_frame_cells) * c_BYTES);
        assign w_drop_sum    = {1'b0, r_drop} + 17'(w_proto_err) + 17'(w_last_drop);

        assign w_rd_ok   = data_fifo_rd[i] & (r_rd_ptr != r_commit_ptr);
        assign w_cell_rd = r_cell_mem[r_rd_ptr[c_AW-1:0]];
        assign w_byte    = w_cell_rd[(CELL_W-1) - (int'(r_byte_idx) * OUT_W) -: OUT_W];

        assign w_used       = r_wr_ptr - r_rd_ptr;
        assign w_free_cells = 32'(DEPTH_CELLS) - 32'(w_used);
        assign w_free_ptrs  = 32'(PTR_DEPTH) - 32'(w_pf_cnt);

        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_wr_ptr      <= '0;
                r_frame_start <= '0;
                r_commit_ptr  <= '0;
                r_rd_ptr      <= '0;
                r_in_frame    <= 1'b0;
                r_bad         <= 1'b0;
                r_byte_idx    <= '0;
                r_dout        <= '0;
                r_drop        <= '0;
                r_pf_wr       <= '0;
                r_pf_rd       <= '0;
            end else begin
                r_wr_ptr      <= w_last_drop ? w_fs_next : w_wr_adv;
                r_frame_start <= w_fs_next;
                if (w_active) begin
                    r_in_frame <= ~o_cell_last;
                end
                r_bad <= w_last ? 1'b0 : w_bad_next;
                if (w_push) begin
                    r_commit_ptr <= w_wr_adv;
                    r_pf_wr      <= r_pf_wr + 1'b1;
                end
                if (w_pop) begin
                    r_pf_rd <= r_pf_rd + 1'b1;
                end
                r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
                if (w_rd_ok) begin
                    r_dout <= w_byte;
                    if (r_byte_idx == c_LAST_BYTE) begin
                        r_byte_idx <= '0;
                        r_rd_ptr   <= r_rd_ptr + 1'b1;
                    end else begin
                        r_byte_idx <= r_byte_idx + 1'b1;
                    end
                end
            end
        end

        // Storage arrays carry no reset; the pointers define what is valid.
        always_ff @(posedge clk) begin
            if (rstn && w_store) begin
                r_cell_mem[w_base[c_AW-1:0]] <= o_cell_fifo_din;
            end
            if (rstn && w_push) begin
                r_ptr_mem[r_pf_wr[c_PW-1:0]] <= w_frame_bytes;
            end
        end

        assign data_fifo_dout[i*OUT_W +: OUT_W] = r_dout;
        assign ptr_fifo_dout[i*16 +: 16]        = w_pf_empty ? 16'd0 : r_ptr_mem[r_pf_rd[c_PW-1:0]];
        assign ptr_fifo_empty[i]                = w_pf_empty;
        assign drop_cnt[i*16 +: 16]             = r_drop;
        assign o_cell_bp[i] = (w_free_cells < 32'(BP_MARGIN)) || (w_free_ptrs < 32'd2);
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_post_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_post_array
// Purpose  : Self-checking bench for switch_post_array. Stimulus pushes
//            expected pointer words and bytes into per-port queues; a monitor
//            pops and compares whenever a pop or byte read takes effect.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_post_array;

    logic          clk = 1'b0;
    logic          rstn;
    logic          o_cell_fifo_wr;
    logic [3:0]    o_cell_fifo_sel;
    logic [127:0]  o_cell_fifo_din;
    logic          o_cell_first;
    logic          o_cell_last;
    logic [3:0]    o_cell_bp;
    logic [3:0]    data_fifo_rd;
    logic [31:0]   data_fifo_dout;
    logic [3:0]    ptr_fifo_rd;
    logic [63:0]   ptr_fifo_dout;
    logic [3:0]    ptr_fifo_empty;
    logic [63:0]   drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_byte_q [4][$];
    logic [15:0] exp_ptr_q  [4][$];

    always #5 clk = ~clk;

    switch_post_array #(
        .NPORTS(4), .CELL_W(128), .OUT_W(8),
        .DEPTH_CELLS(64), .PTR_DEPTH(16), .BP_MARGIN(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .o_cell_fifo_wr(o_cell_fifo_wr), .o_cell_fifo_sel(o_cell_fifo_sel),
        .o_cell_fifo_din(o_cell_fifo_din), .o_cell_first(o_cell_first),
        .o_cell_last(o_cell_last), .o_cell_bp(o_cell_bp),
        .data_fifo_rd(data_fifo_rd), .data_fifo_dout(data_fifo_dout),
        .ptr_fifo_rd(ptr_fifo_rd), .ptr_fifo_dout(ptr_fifo_dout),
        .ptr_fifo_empty(ptr_fifo_empty), .drop_cnt(drop_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] make_cell(input int tag);
        logic [127:0] c;
        for (int k = 0; k < 16; k++) c[127-8*k -: 8] = 8'(tag * 7 + k * 13);
        return c;
    endfunction

    // Monitor: inputs change at posedge+1, so the negedge sees stable values.
    logic [3:0] pend = 4'b0;
    logic [7:0] last_exp [4];
    always @(negedge clk) begin
        logic [7:0]  e;
        logic [15:0] ep;
        if (!rstn) begin
            pend = 4'b0;
            for (int p = 0; p < 4; p++) last_exp[p] = 8'd0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (pend[p]) begin
                    // An ignored read must leave the last byte in place.
                    e = (exp_byte_q[p].size() > 0) ? exp_byte_q[p].pop_front() : last_exp[p];
                    last_exp[p] = e;
                    check($sformatf("byte_p%0d", p), 64'(data_fifo_dout[p*8 +: 8]), 64'(e));
                end
                if (ptr_fifo_rd[p]) begin
                    ep = (exp_ptr_q[p].size() > 0) ? exp_ptr_q[p].pop_front() : 16'd0;
                    check($sformatf("ptr_p%0d", p), 64'(ptr_fifo_dout[p*16 +: 16]), 64'(ep));
                end
            end
            pend = data_fifo_rd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cell(input logic [3:0] sel, input logic first, input logic last, input int tag);
        o_cell_fifo_wr  = 1'b1;
        o_cell_fifo_sel = sel;
        o_cell_first    = first;
        o_cell_last     = last;
        o_cell_fifo_din = make_cell(tag);
        tick();
        o_cell_fifo_wr  = 1'b0;
        o_cell_fifo_sel = 4'b0;
        o_cell_first    = 1'b0;
        o_cell_last     = 1'b0;
    endtask

    // Sends an n-cell frame; when it is expected to commit, queue its
    // pointer word and bytes on every selected port.
    task automatic send_frame(input logic [3:0] sel, input int n, input int tag,
                              input logic commit, input logic [15:0] ptr_word);
        logic [127:0] c;
        for (int j = 0; j < n; j++) send_cell(sel, j == 0, j == n - 1, tag + j);
        if (commit) begin
            for (int p = 0; p < 4; p++) begin
                if (sel[p]) begin
                    exp_ptr_q[p].push_back(ptr_word);
                    for (int j = 0; j < n; j++) begin
                        c = make_cell(tag + j);
                        for (int k = 0; k < 16; k++) exp_byte_q[p].push_back(c[127-8*k -: 8]);
                    end
                end
            end
        end
    endtask

    task automatic read_port(input int p, input int nbytes);
        for (int j = 0; j < nbytes; j++) begin
            data_fifo_rd[p] = 1'b1;
            tick();
        end
        data_fifo_rd[p] = 1'b0;
        tick();
    endtask

    task automatic pop_ptr(input int p);
        ptr_fifo_rd[p] = 1'b1;
        tick();
        ptr_fifo_rd[p] = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dout"},  64'(data_fifo_dout), 64'd0);
        check({tag, "_empty"}, 64'(ptr_fifo_empty), 64'hF);
        check({tag, "_ptr"},   ptr_fifo_dout, 64'd0);
        check({tag, "_drop"},  drop_cnt, 64'd0);
        check({tag, "_bp"},    64'(o_cell_bp), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        o_cell_fifo_wr = 1'b0; o_cell_fifo_sel = 4'b0; o_cell_fifo_din = '0;
        o_cell_first = 1'b0; o_cell_last = 1'b0;
        data_fifo_rd = 4'b0; ptr_fifo_rd = 4'b0;
        tick(); tick();
        check_reset_state("reset");
        rstn = 1'b1;
        tick();

        // Unicast 3-cell frame to port 0.
        send_frame(4'b0001, 3, 16, 1'b1, 16'd48);
        check("uni_empty", 64'(ptr_fifo_empty), 64'b1110);
        pop_ptr(0);
        read_port(0, 48);
        check("uni_empty_after", 64'(ptr_fifo_empty), 64'b1111);

        // Multicast single cell to ports 1 and 3.
        send_frame(4'b1010, 1, 40, 1'b1, 16'd16);
        check("mc_empty", 64'(ptr_fifo_empty), 64'b0101);
        pop_ptr(1);
        pop_ptr(3);
        read_port(1, 16);
        read_port(3, 16);
        check("mc_drop", drop_cnt, 64'd0);

        // Non-first cell outside a frame is ignored without a count.
        send_cell(4'b0100, 1'b0, 1'b1, 90);
        check("stray_empty", 64'(ptr_fifo_empty[2]), 64'd1);
        check("stray_drop", 64'(drop_cnt[32 +: 16]), 64'd0);

        // Protocol error on port 2: open frame restarted by a new first.
        send_cell(4'b0100, 1'b1, 1'b0, 100);
        send_cell(4'b0100, 1'b0, 1'b0, 101);
        send_frame(4'b0100, 2, 110, 1'b1, 16'd32);
        check("proto_drop", 64'(drop_cnt[32 +: 16]), 64'd1);
        pop_ptr(2);
        read_port(2, 32);
        read_port(2, 1);   // nothing committed: read ignored, byte holds

        // Overflow on port 0: 63 cells committed, then a 3-cell frame.
        send_frame(4'b0001, 63, 200, 1'b1, 16'd1008);
        check("ovf_bp", 64'(o_cell_bp[0]), 64'd1);
        send_frame(4'b0001, 3, 50, 1'b0, 16'd0);
        check("ovf_drop", 64'(drop_cnt[15:0]), 64'd1);
        pop_ptr(0);
        check("ovf_empty", 64'(ptr_fifo_empty[0]), 64'd1);
        read_port(0, 1008);
        send_frame(4'b0001, 1, 70, 1'b1, 16'd16);
        pop_ptr(0);
        read_port(0, 16);

        // Backpressure on port 1 at the BP_MARGIN boundary.
        send_frame(4'b0010, 60, 300, 1'b1, 16'd960);
        check("bp_60", 64'(o_cell_bp[1]), 64'd0);
        send_frame(4'b0010, 1, 400, 1'b1, 16'd16);
        check("bp_61", 64'(o_cell_bp[1]), 64'd1);
        read_port(1, 16);
        check("bp_freed", 64'(o_cell_bp[1]), 64'd0);
        read_port(1, 960);
        pop_ptr(1);
        pop_ptr(1);
        check("bp_all_empty", 64'(ptr_fifo_empty), 64'hF);

        // Reset with a committed frame on port 3 and an open frame on port 0.
        send_frame(4'b1000, 1, 500, 1'b1, 16'd16);
        send_cell(4'b0001, 1'b1, 1'b0, 510);
        rstn = 1'b0;
        for (int p = 0; p < 4; p++) begin
            exp_byte_q[p].delete();
            exp_ptr_q[p].delete();
        end
        tick();
        check_reset_state("midrst");
        rstn = 1'b1;
        tick();
        send_frame(4'b0001, 1, 600, 1'b1, 16'd16);
        check("post_rst_empty", 64'(ptr_fifo_empty), 64'b1110);
        pop_ptr(0);
        read_port(0, 16);

        tick();
        for (int p = 0; p < 4; p++) begin
            check($sformatf("leftover_bytes_p%0d", p), 64'(exp_byte_q[p].size()), 64'd0);
            check($sformatf("leftover_ptrs_p%0d", p),  64'(exp_ptr_q[p].size()),  64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
